// File: rtl/scfifo_stream_reader.sv
// scfifo_stream_reader: drains a non-show-ahead single-clock FIFO into a valid/ready stream.
// Defining SCFIFO_READER_FLUSH_EN adds a synchronous flush input that discards all buffered and in-flight words.
module scfifo_stream_reader #(
   parameter int WIDTH        = 20,
   parameter int READ_LATENCY = 2
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             fifo_empty,
   output logic             fifo_rdreq,
   input  logic [WIDTH-1:0] fifo_q,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
`ifdef SCFIFO_READER_FLUSH_EN
   input  logic             flush,
`endif
   output logic [2:0]       buffered
);

   localparam int PF_DEPTH = READ_LATENCY + 2;
   localparam int PTR_W    = 2;
   localparam int CNT_W    = 3;

   if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
      $error("scfifo_stream_reader: READ_LATENCY must be 1 or 2");
   end

   logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic                    out_valid_q, out_valid_d;
   logic [WIDTH-1:0]        mem_q [PF_DEPTH];
   logic [WIDTH-1:0]        mem_d [PF_DEPTH];
`ifdef SCFIFO_READER_FLUSH_EN
   logic [READ_LATENCY-1:0] disc_pipe_q, disc_pipe_d;
`endif

   logic [CNT_W-1:0] occ;
   logic             push;
   logic             pop;
   logic             rd_block;

   // Pointers wrap on an explicit compare because PF_DEPTH is 3 when READ_LATENCY is 1.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(PF_DEPTH - 1)) begin
         return '0;
      end
      return ptr + PTR_W'(1);
   endfunction

   // Occupancy counts words already buffered plus words requested but not yet returned.
   always_comb begin
      // NOTE: every variable written in always_comb gets a value before any conditional logic, so no latch is inferred.
      occ = count_q;
      for (int i = 0; i < READ_LATENCY; i++) begin
         occ = occ + CNT_W'(vld_pipe_q[i]);
      end
   end

`ifdef SCFIFO_READER_FLUSH_EN
   assign rd_block = flush;
   assign push     = vld_pipe_q[READ_LATENCY-1] & ~disc_pipe_q[READ_LATENCY-1] & ~flush;
`else
   assign rd_block = 1'b0;
   assign push     = vld_pipe_q[READ_LATENCY-1];
`endif

   assign fifo_rdreq = ~aclr & ~fifo_empty & (occ < CNT_W'(PF_DEPTH)) & ~rd_block;
   assign pop        = out_valid_q & out_ready;

   always_comb begin
      vld_pipe_d    = '0;
      vld_pipe_d[0] = fifo_rdreq;
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
      end

      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = fifo_q;
      end

`ifdef SCFIFO_READER_FLUSH_EN
      // Anything in flight at a flush edge is tagged so it is dropped when it reaches the buffer.
      disc_pipe_d = '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
         disc_pipe_d[i] = vld_pipe_q[i-1] & (disc_pipe_q[i-1] | flush);
      end
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
`endif

      out_valid_d = (count_d != '0);
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         vld_pipe_q  <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         // NOTE: the buffer array is reset because out_data must read 0 after reset; a RAM-style array would normally be left unreset.
         for (int i = 0; i < PF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef SCFIFO_READER_FLUSH_EN
         disc_pipe_q <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         vld_pipe_q  <= vld_pipe_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         mem_q       <= mem_d;
`ifdef SCFIFO_READER_FLUSH_EN
         disc_pipe_q <= disc_pipe_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = mem_q[rd_ptr_q];
   assign buffered  = count_q;

endmodule

// File: tb/tb_scfifo_stream_reader.sv
// Self-checking bench for scfifo_stream_reader: behavioural FIFO with two-cycle read latency,
// scoreboard of written words, directed reset/latency/throughput/back-pressure/random/flush steps.
module tb_scfifo_stream_reader;
   localparam int WIDTH    = 20;
   localparam int RL       = 2;
   localparam int PF_DEPTH = RL + 2;

   logic             clock      = 1'b0;
   logic             aclr       = 1'b1;
   logic             fifo_empty = 1'b1;
   logic             out_ready  = 1'b0;
   logic [WIDTH-1:0] fifo_q     = '0;
   logic             fifo_rdreq;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       buffered;
`ifdef SCFIFO_READER_FLUSH_EN
   logic             flush      = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rd_cnt = 0;

   logic [WIDTH-1:0] fifo_mem [$];
   logic [WIDTH-1:0] sb [$];
   logic [WIDTH-1:0] st1  = '0;
   logic             rd_s = 1'b0;

   scfifo_stream_reader #(.WIDTH(WIDTH), .READ_LATENCY(RL)) dut (
      .clock      (clock),
      .aclr       (aclr),
      .fifo_empty (fifo_empty),
      .fifo_rdreq (fifo_rdreq),
      .fifo_q     (fifo_q),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
`ifdef SCFIFO_READER_FLUSH_EN
      .flush      (flush),
`endif
      .buffered   (buffered)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [WIDTH-1:0] w);
      fifo_mem.push_back(w);
      sb.push_back(w);
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clock);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain(input string tag, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clock);
         if (sb.size() == 0) break;
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   // FIFO model: rdreq sampled at edge E0 lands in st1, appears on fifo_q after E1.
   always @(posedge clock) begin
      cyc++;
      #1;
      fifo_q = st1;
      if (rd_s && fifo_mem.size() != 0) begin
         st1 = fifo_mem.pop_front();
      end
      fifo_empty = (fifo_mem.size() == 0);
   end

   // Monitor: invariants every cycle and scoreboard comparison on each accepted word.
   always @(negedge clock) begin
      rd_s = fifo_rdreq;
      if (fifo_rdreq) rd_cnt++;
      check("buffered_le_depth", 32'(buffered <= 3'(PF_DEPTH)), 32'd1);
      check("rdreq_while_empty", 32'(fifo_rdreq & fifo_empty), 32'd0);
      if (out_valid && out_ready) begin
         check("word_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            check("out_data", 32'(out_data), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      int cyc_r;
      int cyc_v;
      int n;
      int rd_before;
      bit ok;

      // Reset with a non-empty FIFO: nothing may be requested or presented.
      for (int i = 0; i < 3; i++) write_word(WIDTH'(i));
      repeat (5) begin
         @(negedge clock);
         check("reset_rdreq", 32'(fifo_rdreq), 32'd0);
         check("reset_out_valid", 32'(out_valid), 32'd0);
         check("reset_buffered", 32'(buffered), 32'd0);
         check("reset_out_data", 32'(out_data), 32'd0);
      end

      // Latency: first out_valid three cycles after first rdreq, then back-to-back words.
      step();
      aclr      = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      check("first_rdreq", 32'(fifo_rdreq), 32'd1);
      cyc_r = cyc;
      wait_valid(20, ok);
      check("latency_timeout", 32'(ok), 32'd1);
      cyc_v = cyc;
      check("latency_cycles", 32'(cyc_v - cyc_r), 32'd3);
      repeat (2) begin
         @(negedge clock);
         check("latency_consecutive", 32'(out_valid), 32'd1);
      end
      @(negedge clock);
      check("latency_idle", 32'(out_valid), 32'd0);

      // Throughput: 1000 words, out_ready held high, no bubbles allowed.
      step();
      for (int i = 0; i < 1000; i++) write_word(WIDTH'(i));
      wait_valid(20, ok);
      check("tput_timeout", 32'(ok), 32'd1);
      n = 1;
      for (int k = 0; k < 1100; k++) begin
         @(negedge clock);
         if (!out_valid) break;
         n++;
      end
      check("tput_run_length", 32'(n), 32'd1000);
      check("tput_sb_empty", 32'(sb.size()), 32'd0);

      // Back-pressure: exactly PF_DEPTH reads, head word held stable.
      step();
      out_ready = 1'b0;
      rd_before = rd_cnt;
      for (int i = 0; i < 10; i++) write_word(WIDTH'(2000 + i));
      repeat (20) @(negedge clock);
      check("bp_rdreq_count", 32'(rd_cnt - rd_before), 32'(PF_DEPTH));
      check("bp_buffered", 32'(buffered), 32'(PF_DEPTH));
      check("bp_rdreq_low", 32'(fifo_rdreq), 32'd0);
      repeat (4) begin
         @(negedge clock);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data_hold", 32'(out_data), 32'd2000);
      end
      step();
      out_ready = 1'b1;
      drain("bp_drain", 100);
      @(negedge clock);
      check("bp_idle_valid", 32'(out_valid), 32'd0);
      check("bp_idle_buffered", 32'(buffered), 32'd0);

      // Random writes and back-pressure; the monitor compares every delivered word.
      for (int k = 0; k < 20000; k++) begin
         step();
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) write_word(WIDTH'($urandom));
      end
      step();
      out_ready = 1'b1;
      drain("rand_drain", 5000);
      @(negedge clock);
      check("rand_idle_buffered", 32'(buffered), 32'd0);

`ifdef SCFIFO_READER_FLUSH_EN
      // Flush with three words buffered and one still in flight.
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word(WIDTH'(3000 + i));
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (buffered == 3'd2) begin
            ok = 1'b1;
            break;
         end
      end
      check("flush_setup_timeout", 32'(ok), 32'd1);
      step();
      flush = 1'b1;
      sb.delete();
      @(negedge clock);
      check("flush_pre_buffered", 32'(buffered), 32'd3);
      check("flush_rdreq_low", 32'(fifo_rdreq), 32'd0);
      step();
      flush = 1'b0;
      @(negedge clock);
      check("flush_buffered", 32'(buffered), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      step();
      write_word(WIDTH'(4000));
      out_ready = 1'b1;
      wait_valid(20, ok);
      check("flush_next_timeout", 32'(ok), 32'd1);
      check("flush_next_word", 32'(out_data), 32'd4000);
      drain("flush_drain", 50);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
